// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: FSM state encoding
// and fetch-pair geometry.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_BYTES   = 8;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFF8;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_flush_counter.sv
// Counts the unstalled cycles of a repair flush; reload restarts the window.
module fetch_flush_counter #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  localparam int unsigned CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(FLUSH_CYCLES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Done marks the last flush cycle, so the exit can happen on that same edge.
  assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Owns the fetch PC of the two-wide front end and drives the fetch2 slot-kill
// controls through a BOOT/RUN/FLUSH state machine.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_mispred_i,
  input  logic        wasnt_branch_i,
  input  logic [31:0] repair_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  output logic [31:0] pc_o,
  output logic        fetch_en_o,
  output logic        zero_0_o,
  output logic        zero_1_o,
  output logic        flush_active_o
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic         r_kill0;
  logic         r_kill1;
  logic         r_odd;
  logic         w_repair;
  logic         w_repair_take;
  logic         w_flush_dec;
  logic         w_flush_done;
  logic         w_flush_exit;

  assign w_repair      = branch_mispred_i | wasnt_branch_i;
  assign w_repair_take = w_repair && (r_state != ST_BOOT);
  assign w_flush_dec   = (r_state == ST_FLUSH) && !stall_i && !w_repair;
  assign w_flush_exit  = w_flush_dec && w_flush_done;

  fetch_flush_counter #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_counter (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .i_load (w_repair_take),
    .i_dec  (w_flush_dec),
    .o_done (w_flush_done)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BOOT:  w_next_state = ST_RUN;
      ST_RUN:   if (w_repair) w_next_state = ST_FLUSH;
      ST_FLUSH: begin
        if (w_repair) begin
          w_next_state = ST_FLUSH;
        end else if (w_flush_exit) begin
          w_next_state = ST_RUN;
        end
      end
      default:  w_next_state = ST_BOOT;
    endcase
  end

  // Repair outranks prediction; an odd repair/target PC kills slot0 of the pair.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_pc    <= RESET_PC;
      r_kill0 <= 1'b0;
      r_kill1 <= 1'b0;
      r_odd   <= 1'b0;
    end else if (w_repair_take) begin
      r_pc  <= align_pc(repair_pc_i);
      r_odd <= repair_pc_i[2];
    end else if ((r_state == ST_RUN) && !stall_i) begin
      if (pred_taken_i) begin
        r_pc    <= align_pc(pred_target_i);
        r_kill0 <= pred_target_i[2];
        r_kill1 <= 1'b1;
      end else begin
        r_pc    <= r_pc + 32'(FETCH_BYTES);
        r_kill0 <= 1'b0;
        r_kill1 <= 1'b0;
      end
    end else if (w_flush_exit) begin
      r_kill0 <= r_odd;
      r_kill1 <= 1'b0;
    end
  end

  always_comb begin
    pc_o           = align_pc(r_pc);
    fetch_en_o     = 1'b0;
    flush_active_o = 1'b0;
    zero_0_o       = 1'b1;
    zero_1_o       = 1'b1;
    case (r_state)
      ST_RUN: begin
        fetch_en_o = 1'b1;
        zero_0_o   = w_repair | r_kill0;
        zero_1_o   = w_repair | r_kill1;
      end
      ST_FLUSH: begin
        fetch_en_o     = 1'b1;
        flush_active_o = 1'b1;
      end
      default: begin
        fetch_en_o = 1'b0;
      end
    endcase
  end

endmodule
